// File: rtl/exec_run_monitor.sv
// ============================================================================
// Module      : exec_run_monitor
// Description : Run controller and watchdog for the mRisc core/memory pair.
//               It gates the core clock-enable, counts cycles, fetches and
//               pipeline stages, and drains then freezes on the halt opcode.
//               Define TRACE_FIFO_EN to build the memory-write trace FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_run_monitor #(
    parameter int          DW          = 8,
    parameter int          AW          = 8,
    parameter int          IW          = 16,
    parameter int unsigned HALT_OP     = 'h2fff,
    parameter int          DRAIN_CYC   = 4,
    parameter int          NSTAGES     = 4,
    parameter int          CW          = 32,
    parameter int unsigned MAX_CYC     = 0,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IW-1:0]    RI,
    input  logic             RIValid,
    input  logic             EscMem,
    input  logic [AW-1:0]    Endereco,
    input  logic [DW-1:0]    ValorEscrito,
    input  logic [AW-1:0]    WatchAddr,
    output logic             Run,
    output logic             Halted,
    output logic             Timeout,
    output logic [7:0]       StageCnt,
    output logic [CW-1:0]    CycleCnt,
    output logic [CW-1:0]    InstrCnt,
    output logic             WatchHit,
    output logic [DW-1:0]    WatchData,
    input  logic             TrRd,
    output logic [AW+DW-1:0] TrData,
    output logic             TrEmpty,
    output logic             TrOvf
);

    localparam int            c_dcw        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_dcw-1:0] c_drain_ld = c_dcw'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [CW-1:0] c_max_m1     = CW'((MAX_CYC > 0) ? MAX_CYC - 1 : 0);
    localparam logic [IW-1:0] c_halt_op    = IW'(HALT_OP);
    localparam logic [7:0]    c_nstages    = 8'(NSTAGES);
    localparam logic [CW-1:0] c_cnt_max    = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_dcw-1:0]   r_drain;
    logic [c_dcw-1:0]   w_drain_nxt;
    logic               w_start_run;
    logic               w_set_halted;
    logic               w_set_timeout;
    logic               w_run;
    logic               w_halt_fetch;
    logic               w_wdog;

    logic               r_halted;
    logic               r_timeout;
    logic [7:0]         r_stage;
    logic [CW-1:0]      r_cycle;
    logic [CW-1:0]      r_instr;
    logic               r_watch_hit;
    logic [DW-1:0]      r_watch_data;

    assign w_run        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_halt_fetch = RIValid && (RI == c_halt_op);
    assign w_wdog       = (MAX_CYC != 0) && (r_cycle == c_max_m1);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // A halt fetch in the watchdog's final cycle takes the drain path.
    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain;
        w_start_run   = 1'b0;
        w_set_halted  = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            S_RUN: begin
                if (w_halt_fetch) begin
                    if (DRAIN_CYC == 0) begin
                        w_state_nxt  = S_DONE;
                        w_set_halted = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = c_drain_ld;
                    end
                end else if (w_wdog) begin
                    w_state_nxt   = S_DONE;
                    w_set_timeout = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) begin
                    w_state_nxt  = S_DONE;
                    w_set_halted = 1'b1;
                end else begin
                    w_drain_nxt = r_drain - c_dcw'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset || w_start_run) begin
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_stage   <= 8'd1;
            r_cycle   <= '0;
            r_instr   <= '0;
        end else begin
            if (w_set_halted) begin
                r_halted <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
            if (w_run) begin
                r_stage <= (r_stage == c_nstages) ? 8'd1 : r_stage + 8'd1;
                if (r_cycle != c_cnt_max) begin
                    r_cycle <= r_cycle + CW'(1);
                end
            end
            // Fetches during drain belong to the squashed tail, not the run.
            if ((r_state == S_RUN) && RIValid && (r_instr != c_cnt_max)) begin
                r_instr <= r_instr + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_watch_hit  <= 1'b0;
            r_watch_data <= '0;
        end else begin
            if (w_start_run) begin
                r_watch_hit <= 1'b0;
            end else if (w_run && EscMem && (Endereco == WatchAddr)) begin
                r_watch_hit  <= 1'b1;
                r_watch_data <= ValorEscrito;
            end
        end
    end

    assign Run       = w_run;
    assign Halted    = r_halted;
    assign Timeout   = r_timeout;
    assign StageCnt  = r_stage;
    assign CycleCnt  = r_cycle;
    assign InstrCnt  = r_instr;
    assign WatchHit  = r_watch_hit;
    assign WatchData = r_watch_data;

`ifdef TRACE_FIFO_EN
    localparam int              c_pw    = $clog2(TRACE_DEPTH);
    localparam logic [c_pw:0]   c_depth = (c_pw + 1)'(TRACE_DEPTH);

    logic [AW+DW-1:0] r_mem [TRACE_DEPTH];
    logic [c_pw-1:0]  r_wr;
    logic [c_pw-1:0]  r_rd;
    logic [c_pw:0]    r_cnt;
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;

    assign w_push    = w_run && EscMem;
    assign w_full    = (r_cnt == c_depth);
    assign w_pop     = TrRd && (r_cnt != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= {Endereco, ValorEscrito};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset || w_start_run) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_pw'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_cnt <= r_cnt + (c_pw + 1)'(1);
            end else if (w_pop && !w_push_ok) begin
                r_cnt <= r_cnt - (c_pw + 1)'(1);
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign TrData  = (r_cnt == '0) ? '0 : r_mem[r_rd];
    assign TrEmpty = (r_cnt == '0);
    assign TrOvf   = r_ovf;
`else
    localparam int c_unused_depth = TRACE_DEPTH;
    logic          w_unused_trrd;

    assign w_unused_trrd = TrRd;
    assign TrData        = '0;
    assign TrEmpty       = 1'b1;
    assign TrOvf         = 1'b0;
`endif

endmodule

`default_nettype wire
